// File: rtl/u_game_judge_gen_if.sv
// Signal bundle between the note scheduler / player input and the judgment generator.
// The slave modport is the judge itself; the master modport drives notes and button.
interface u_game_judge_gen_if;
  logic       i_note_start;
  logic       i_btn;
  logic [1:0] o_judge;
  logic       o_judge_valid;
  logic [7:0] o_combo;
  logic       o_overrun;

  modport slave (
    input  i_note_start,
    input  i_btn,
    output o_judge,
    output o_judge_valid,
    output o_combo,
    output o_overrun
  );

  modport master (
    output i_note_start,
    output i_btn,
    input  o_judge,
    input  o_judge_valid,
    input  o_combo,
    input  o_overrun
  );
endinterface

// File: rtl/u_game_judge_gen.sv
// Grades a button press against a tick-based timing window, holds the judgment
// for a fixed display time and keeps a saturating combo count.
module u_game_judge_gen #(
  parameter int TICK_DIV    = 50000,
  parameter int NORMAL_WIN  = 100,
  parameter int PERFECT_WIN = 30,
  parameter int HOLD_TICKS  = 500
) (
  input  logic                clk,
  input  logic                rst,
  u_game_judge_gen_if.slave   bus
);
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int WIN_W  = $clog2(2 * NORMAL_WIN + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [WIN_W-1:0]  WIN_MAX   = WIN_W'(2 * NORMAL_WIN);
  localparam logic [WIN_W-1:0]  WIN_MID   = WIN_W'(NORMAL_WIN);
  localparam logic [WIN_W-1:0]  WIN_PERF  = WIN_W'(PERFECT_WIN);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic {ST_IDLE, ST_WINDOW} state_t;

  state_t            state_reg, state_next;
  logic              btn_ff1_reg, btn_ff2_reg, btn_prev_reg;
  logic [PRE_W-1:0]  presc_reg;
  logic [WIN_W-1:0]  win_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [1:0]        judge_reg;
  logic              judge_valid_reg;
  logic [7:0]        combo_reg;
  logic              overrun_reg;

  logic              press;
  logic              tick;
  logic [WIN_W-1:0]  offset;
  logic              win_clr, win_inc, load, overrun_set;
  logic [1:0]        load_code;

  assign press  = btn_ff2_reg & ~btn_prev_reg;
  assign tick   = (presc_reg == PRE_LAST);
  assign offset = (win_cnt_reg >= WIN_MID) ? (win_cnt_reg - WIN_MID) : (WIN_MID - win_cnt_reg);

  // Button is asynchronous: two flops before the edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_ff1_reg  <= 1'b0;
      btn_ff2_reg  <= 1'b0;
      btn_prev_reg <= 1'b0;
    end else begin
      btn_ff1_reg  <= bus.i_btn;
      btn_ff2_reg  <= btn_ff1_reg;
      btn_prev_reg <= btn_ff2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.i_note_start) state_next = ST_WINDOW;
      ST_WINDOW: if (press || (tick && win_cnt_reg == WIN_MAX)) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // A press beats a simultaneous timeout tick; by then the offset is NORMAL_WIN anyway.
  always_comb begin
    win_clr     = 1'b0;
    win_inc     = 1'b0;
    load        = 1'b0;
    load_code   = 2'b00;
    overrun_set = 1'b0;
    case (state_reg)
      ST_IDLE: win_clr = bus.i_note_start;
      ST_WINDOW: begin
        overrun_set = bus.i_note_start;
        if (press) begin
          load      = 1'b1;
          load_code = (offset <= WIN_PERF) ? 2'b11 : 2'b10;
        end else if (tick) begin
          if (win_cnt_reg == WIN_MAX) begin
            load      = 1'b1;
            load_code = 2'b01;
          end else begin
            win_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Restarting the prescaler on window open aligns the first tick TICK_DIV clks later.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg   <= '0;
      win_cnt_reg <= '0;
    end else begin
      if (win_clr || tick) presc_reg <= '0;
      else                 presc_reg <= presc_reg + 1'b1;
      if (win_clr)      win_cnt_reg <= '0;
      else if (win_inc) win_cnt_reg <= win_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      judge_reg       <= 2'b00;
      judge_valid_reg <= 1'b0;
      hold_cnt_reg    <= '0;
      combo_reg       <= 8'd0;
      overrun_reg     <= 1'b0;
    end else begin
      judge_valid_reg <= load;
      overrun_reg     <= overrun_set;
      if (load) begin
        judge_reg    <= load_code;
        hold_cnt_reg <= '0;
        if (load_code == 2'b01)     combo_reg <= 8'd0;
        else if (combo_reg != 8'hFF) combo_reg <= combo_reg + 8'd1;
      end else if (judge_reg != 2'b00 && tick) begin
        if (hold_cnt_reg == HOLD_LAST) begin
          judge_reg    <= 2'b00;
          hold_cnt_reg <= '0;
        end else begin
          hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.o_judge       = judge_reg;
  assign bus.o_judge_valid = judge_valid_reg;
  assign bus.o_combo       = combo_reg;
  assign bus.o_overrun     = overrun_reg;
endmodule

// File: tb/tb_u_game_judge_gen.sv
// Directed bench with a judgment scoreboard: stimulus pushes expected codes,
// a negedge monitor pops and compares whenever o_judge_valid pulses.
module tb_u_game_judge_gen;
  localparam int TICK_DIV = 4, NORMAL_WIN = 10, PERFECT_WIN = 3, HOLD_TICKS = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  u_game_judge_gen_if bus ();

  u_game_judge_gen #(
    .TICK_DIV(TICK_DIV), .NORMAL_WIN(NORMAL_WIN),
    .PERFECT_WIN(PERFECT_WIN), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed { logic [1:0] judge; logic [7:0] combo; } exp_t;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_combo = 0;
  int   n_overrun_seen = 0;
  int   n_overrun_exp  = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] code);
    if (code == 2'b01)      exp_combo = 0;
    else if (exp_combo < 255) exp_combo++;
    exp_q.push_back({code, 8'(exp_combo)});
  endtask

  // Monitor: one line per judgment, compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_overrun) n_overrun_seen++;
      if (bus.o_judge_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_judgment: got judge=%b combo=%0d expected none", bus.o_judge, bus.o_combo);
        end else begin
          e = exp_q.pop_front();
          check("judge", int'(bus.o_judge), int'(e.judge));
          check("combo", int'(bus.o_combo), int'(e.combo));
          $display("judgment judge=%b combo=%0d (expected %b/%0d) t=%0t",
                   bus.o_judge, bus.o_combo, e.judge, e.combo, $time);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Leaves the caller at the negedge just after the accepting posedge p.
  task automatic open_note();
    @(negedge clk); bus.i_note_start = 1'b1;
    @(negedge clk); bus.i_note_start = 1'b0;
  endtask

  // Button rises after n_wait negedges; press is graded at edge p + n_wait + 3.
  task automatic note_press(input int n_wait, input logic [1:0] code, input int ovr_at);
    open_note();
    push_exp(code);
    for (int i = 0; i < n_wait; i++) begin
      @(negedge clk);
      if (ovr_at != 0 && i == ovr_at + 1) check("overrun_pulse", int'(bus.o_overrun), 1);
      bus.i_note_start = (ovr_at != 0 && i == ovr_at);
    end
    bus.i_note_start = 1'b0;
    bus.i_btn = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    bus.i_note_start = 1'b0;
    bus.i_btn        = 1'b0;

    // Reset with a toggling button, then presses while IDLE.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.i_btn = ~bus.i_btn;
    end
    @(negedge clk);
    check("reset_judge", int'(bus.o_judge), 0);
    check("reset_combo", int'(bus.o_combo), 0);
    check("reset_valid", int'(bus.o_judge_valid), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus.i_btn = ~bus.i_btn;
    end
    bus.i_btn = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_press_judge", int'(bus.o_judge), 0);

    // PERFECT at win_cnt=12, NORMAL at win_cnt=4.
    note_press(47, 2'b11, 0);
    wait_drain();
    note_press(15, 2'b10, 0);
    wait_drain();

    // MISS after 21 ticks, then exactly 20 hold ticks before IDLE.
    open_note();
    push_exp(2'b01);
    repeat (84) @(negedge clk);
    check("miss_judge", int'(bus.o_judge), 1);
    check("miss_combo", int'(bus.o_combo), 0);
    repeat (79) @(negedge clk);
    check("hold_last_cycle", int'(bus.o_judge), 1);
    @(negedge clk);
    check("hold_expired", int'(bus.o_judge), 0);
    wait_drain();

    // Press on the timeout tick wins as NORMAL; PERFECT/NORMAL boundary.
    note_press(81, 2'b10, 0);
    wait_drain();
    note_press(27, 2'b11, 0);
    wait_drain();
    note_press(23, 2'b10, 0);
    wait_drain();

    // Overrun: second note mid-window must not restart timing (still win_cnt=12).
    n_overrun_exp++;
    note_press(47, 2'b11, 20);
    wait_drain();

    // Saturate combo.
    for (int n = 0; n < 256; n++) begin
      note_press(39, 2'b11, 0);
      wait_drain();
    end
    check("combo_saturated", int'(bus.o_combo), 255);

    // Reset in the middle of a window.
    open_note();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_judge", int'(bus.o_judge), 0);
    check("midrst_combo", int'(bus.o_combo), 0);
    check("midrst_valid", int'(bus.o_judge_valid), 0);
    check("midrst_overrun", int'(bus.o_overrun), 0);
    rst = 1'b0;
    exp_combo = 0;
    repeat (120) @(negedge clk);
    check("midrst_no_late_miss", int'(bus.o_judge), 0);

    check("overrun_count", n_overrun_seen, n_overrun_exp);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/u_game_judge_gen.md
Name: u_game_judge_gen

Overview:
Produces the 2-bit judgment code (00 IDLE, 01 MISS, 10 NORMAL, 11 PERFECT) that feeds the 7-segment judgment display. It times the player's button press against a per-note timing window and grades it by distance from the window centre. It holds each judgment for a fixed display time and maintains a combo counter. It sits between the note scheduler, which supplies the window-open pulse, and the display/score logic.

Parameters:
TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz); must be ≥2
NORMAL_WIN, 100, half-width of the hit window in ticks; centre is at tick count NORMAL_WIN
PERFECT_WIN, 30, max |offset| in ticks graded PERFECT; must be < NORMAL_WIN
HOLD_TICKS, 500, ticks a judgment stays on o_judge before it returns to IDLE

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_note_start  in  1  one-clk pulse: the hit window opens (note is NORMAL_WIN ticks before the target)
i_btn  in  1  raw player button, active-high, asynchronous to clk
o_judge  out  2  judgment code for the display: 00 IDLE, 01 MISS, 10 NORMAL, 11 PERFECT
o_judge_valid  out  1  one-clk pulse when a new judgment is loaded
o_combo  out  8  consecutive non-MISS count, saturating at 255
o_overrun  out  1  one-clk pulse when i_note_start arrives while a window is already open

Behaviour:
- Reset (sync, rst=1 at posedge): FSM=IDLE; all outputs 0; sync flops, prescaler, window counter and hold counter are cleared.
- Button path: 2-flop synchronizer, then a previous-value register. A press is ff2 & ~prev. A raw rising edge first sampled at posedge k gives press=1 during the cycle after posedge k+1.
- Prescaler: free-running 0..TICK_DIV-1. tick=1 for one clk when it wraps. It is forced to 0 on the cycle i_note_start is accepted, so the first window tick comes exactly TICK_DIV clks later.
- FSM states:
  - IDLE: presses are ignored. When i_note_start=1: go to WINDOW, set win_cnt=0.
  - WINDOW: win_cnt increments on each tick.
    - A press with d=|win_cnt−NORMAL_WIN| ≤ PERFECT_WIN grades PERFECT (11); otherwise NORMAL (10). Return to IDLE.
    - A tick while win_cnt==2*NORMAL_WIN with no press grades MISS (01). Return to IDLE.
    - If a press and the timeout tick occur in the same cycle, the press wins and grades NORMAL.
    - i_note_start while in WINDOW is ignored for timing and pulses o_overrun for 1 clk.
- Judgment load:
  - Happens on the posedge where the grade is decided.
  - o_judge takes the new code; o_judge_valid=1 for that following cycle; the hold counter is reset to 0.
  - Latency from the first sampling edge of raw i_btn to o_judge update is 3 clk edges (k+2).
- Hold: the hold counter increments on each tick while o_judge≠00. When it reaches HOLD_TICKS, o_judge returns to 00.
  - A new judgment during the hold overrides immediately and restarts the hold.
  - If a load and the hold expiry happen in the same cycle, the load wins.
- Combo: on PERFECT/NORMAL, o_combo = min(o_combo+1, 255). On MISS, o_combo = 0. It updates on the same edge as o_judge.
- i_note_start in IDLE in the same cycle as a press: the window opens and the press is ignored.
- Width rules:
  - win_cnt is clog2(2*NORMAL_WIN+1) bits; the offset uses unsigned subtract of the larger minus the smaller.
  - The hold counter is clog2(HOLD_TICKS+1) bits.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, NORMAL_WIN=10, PERFECT_WIN=3, HOLD_TICKS=20.
1. Reset: hold rst for 3 clks with i_btn toggling → o_judge=00, o_combo=0, o_judge_valid never pulses; presses in IDLE produce no judgment.
2. Pulse i_note_start, press when win_cnt=12 → o_judge=11, o_judge_valid 1 clk, o_combo=1. Then press at win_cnt=4 on a new note → 10, o_combo=2.
3. Pulse i_note_start with no press → after 21 ticks (84 clks + sync) o_judge=01 and o_combo=0. After 20 more ticks o_judge returns to 00.
4. Press aligned to the tick where win_cnt==20 times out → NORMAL (10), not MISS. A press at win_cnt=7 → PERFECT; at win_cnt=6 → NORMAL (boundary).
5. Second i_note_start while in WINDOW → o_overrun 1-clk pulse; win_cnt is not restarted; the judgment still follows the first note's timing.
6. Preload o_combo=255 via 255 PERFECT notes, then one more PERFECT → stays 255. Assert rst mid-window → FSM returns to IDLE, all outputs 0 on the next cycle.
